// File: rtl/uns_div_pkg.sv
// Shared constants and state encoding for the sequential unsigned divider.
package uns_div_pkg;

  localparam int unsigned DIVIDEND_W = 6;
  localparam int unsigned OP_W       = 3;
  localparam int unsigned DIVISOR_W  = 4;
  localparam int unsigned CNT_W      = 3;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [DIVIDEND_W-1:0] DBZ_QUOT = 6'h3F;
  localparam logic [CNT_W-1:0]      CNT_INIT = CNT_W'(DIVIDEND_W - 1);

  typedef enum logic [1:0] {
    StIdle = IDLE,
    StRun  = RUN,
    StDone = DONE
  } state_e;

endpackage

// File: rtl/uns_div_sel.sv
// Divisor operand mux; same select semantics as the accumulator input mux.
module uns_div_sel
  import uns_div_pkg::*;
(
  input  logic [1:0]           i_sel,
  input  logic [OP_W-1:0]      i_data2,
  input  logic [OP_W-1:0]      i_data1,
  output logic [DIVISOR_W-1:0] o_divisor
);

  always_comb begin
    o_divisor = '0;
    unique case (i_sel)
      2'b00: o_divisor = {1'b0, i_data2};
      2'b01: o_divisor = {1'b0, i_data2} + {1'b0, i_data1};
      2'b10: o_divisor = {1'b0, i_data1};
      2'b11: o_divisor = '0;
      default: o_divisor = '0;
    endcase
  end

endmodule

// File: rtl/uns_div.sv
// Restoring shift-subtract unsigned divider: 6-bit dividend, 4-bit divisor,
// one quotient bit per clock with a start/valid handshake.
module uns_div
  import uns_div_pkg::*;
(
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [DIVIDEND_W-1:0] i_dividend,
  input  logic [OP_W-1:0]       i_data2,
  input  logic [OP_W-1:0]       i_data1,
  input  logic [1:0]            i_sel,
  output logic [DIVIDEND_W-1:0] o_quot,
  output logic [DIVISOR_W-1:0]  o_rem,
  output logic                  o_busy,
  output logic                  o_valid,
  output logic                  o_dbz
);

  state_e                  state_q, state_d;
  logic [DIVIDEND_W-1:0]   dvd_q, dvd_d;
  logic [DIVISOR_W-1:0]    dvs_q, dvs_d;
  logic [DIVISOR_W:0]      rem_q, rem_d;
  logic [DIVIDEND_W-1:0]   quot_q, quot_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0]   oquot_q, oquot_d;
  logic [DIVISOR_W-1:0]    orem_q, orem_d;
  logic                    dbz_q, dbz_d;

  logic [DIVISOR_W-1:0]    divisor;
  logic [DIVISOR_W:0]      pr;
  logic [DIVISOR_W:0]      pr_sub;
  logic                    qbit;
  logic [DIVISOR_W:0]      rem_next;

  uns_div_sel u_sel (
    .i_sel     (i_sel),
    .i_data2   (i_data2),
    .i_data1   (i_data1),
    .o_divisor (divisor)
  );

  // Remainder stays below the divisor, so only its low 4 bits feed the shift.
  assign pr       = {rem_q[DIVISOR_W-1:0], dvd_q[cnt_q]};
  assign qbit     = (pr >= {1'b0, dvs_q});
  assign pr_sub   = pr - {1'b0, dvs_q};
  assign rem_next = qbit ? pr_sub : pr;

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    cnt_d   = cnt_q;
    oquot_d = oquot_q;
    orem_d  = orem_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          dvd_d  = i_dividend;
          dvs_d  = divisor;
          rem_d  = '0;
          quot_d = '0;
          cnt_d  = CNT_INIT;
          if (divisor == '0) begin
            oquot_d = DBZ_QUOT;
            orem_d  = '0;
            dbz_d   = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        rem_d  = rem_next;
        quot_d = {quot_q[DIVIDEND_W-2:0], qbit};
        if (cnt_q == '0) begin
          oquot_d = {quot_q[DIVIDEND_W-2:0], qbit};
          orem_d  = rem_next[DIVISOR_W-1:0];
          dbz_d   = 1'b0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      cnt_q   <= '0;
      oquot_q <= '0;
      orem_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      cnt_q   <= cnt_d;
      oquot_q <= oquot_d;
      orem_q  <= orem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign o_quot  = oquot_q;
  assign o_rem   = orem_q;
  assign o_dbz   = dbz_q;
  assign o_busy  = (state_q == StRun);
  assign o_valid = (state_q == StDone);

endmodule

// File: tb/tb_uns_div.sv
// Randomised self-checking bench for uns_div against an arithmetic reference model.
module tb_uns_div;

  logic       clk;
  logic       i_rst_n;
  logic       i_start;
  logic [5:0] i_dividend;
  logic [2:0] i_data2;
  logic [2:0] i_data1;
  logic [1:0] i_sel;
  logic [5:0] o_quot;
  logic [3:0] o_rem;
  logic       o_busy;
  logic       o_valid;
  logic       o_dbz;

  int n_checks = 0;
  int n_fail   = 0;
  int last_q   = 0;

  uns_div dut (
    .clk        (clk),
    .i_rst_n    (i_rst_n),
    .i_start    (i_start),
    .i_dividend (i_dividend),
    .i_data2    (i_data2),
    .i_data1    (i_data1),
    .i_sel      (i_sel),
    .o_quot     (o_quot),
    .o_rem      (o_rem),
    .o_busy     (o_busy),
    .o_valid    (o_valid),
    .o_dbz      (o_dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_divisor(input int sel, input int d2, input int d1);
    case (sel)
      0:       return d2;
      1:       return d2 + d1;
      2:       return d1;
      default: return 0;
    endcase
  endfunction

  // One full transaction from IDLE; optionally disturbs inputs while busy.
  task automatic run_div(input int dvd, input int sel, input int d2, input int d1,
                         input bit disturb);
    int div, eq, er, ez, elat, ebusy, n, nbusy;
    div = ref_divisor(sel, d2, d1);
    if (div == 0) begin
      eq = 63; er = 0; ez = 1; elat = 1; ebusy = 0;
    end else begin
      eq = dvd / div; er = dvd % div; ez = 0; elat = 7; ebusy = 6;
    end
    i_dividend = 6'(dvd);
    i_sel      = 2'(sel);
    i_data2    = 3'(d2);
    i_data1    = 3'(d1);
    i_start    = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    if (div != 0) check_eq("quot_held_on_start", o_quot, last_q);
    n = 0;
    nbusy = 0;
    while (!o_valid && n < 20) begin
      if (o_busy) nbusy++;
      if (o_busy && disturb) begin
        i_start    = 1'($urandom_range(0, 1));
        i_dividend = 6'($urandom);
        i_sel      = 2'($urandom);
        i_data2    = 3'($urandom);
        i_data1    = 3'($urandom);
      end
      @(posedge clk); #1;
      n++;
    end
    i_start = 1'b0;
    check_eq("latency", n + 1, elat);
    check_eq("busy_cycles", nbusy, ebusy);
    check_eq("quot", o_quot, eq);
    check_eq("rem", o_rem, er);
    check_eq("dbz", o_dbz, ez);
    last_q = eq;
    @(posedge clk); #1;
    check_eq("valid_one_cycle", o_valid, 0);
  endtask

  initial begin
    int n, nv;
    i_rst_n = 1'b0;
    i_start = 1'b0;
    i_dividend = '0;
    i_data2 = '0;
    i_data1 = '0;
    i_sel = '0;
    #22;
    check_eq("rst_quot", o_quot, 0);
    check_eq("rst_rem", o_rem, 0);
    check_eq("rst_busy", o_busy, 0);
    check_eq("rst_valid", o_valid, 0);
    check_eq("rst_dbz", o_dbz, 0);
    @(posedge clk); #1;
    i_rst_n = 1'b1;
    @(posedge clk); #1;

    run_div(45, 0, 7, 0, 0);
    run_div(63, 1, 7, 7, 0);
    run_div(63, 2, 0, 1, 0);
    run_div(20, 3, 5, 5, 0);
    run_div(45, 0, 7, 0, 0);
    run_div(5, 0, 6, 0, 0);
    run_div(0, 0, 6, 0, 0);
    run_div(45, 0, 7, 3, 1);
    run_div(33, 1, 2, 3, 1);

    // Start held high: next division accepted one cycle after the valid cycle.
    i_dividend = 6'd50;
    i_sel = 2'd2;
    i_data1 = 3'd3;
    i_start = 1'b1;
    n = 0;
    @(posedge clk); #1;
    while (!o_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("held_first_quot", o_quot, 16);
    n = 0;
    @(posedge clk); #1;
    n++;
    while (!o_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("held_gap", n, 8);
    check_eq("held_second_quot", o_quot, 16);
    check_eq("held_second_rem", o_rem, 2);
    i_start = 1'b0;
    last_q = 16;
    @(posedge clk); #1;

    // Reset during RUN aborts the division.
    i_dividend = 6'd45;
    i_sel = 2'd0;
    i_data2 = 3'd7;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    i_rst_n = 1'b0;
    #1;
    check_eq("mid_rst_quot", o_quot, 0);
    check_eq("mid_rst_rem", o_rem, 0);
    check_eq("mid_rst_busy", o_busy, 0);
    check_eq("mid_rst_valid", o_valid, 0);
    @(posedge clk); #1;
    i_rst_n = 1'b1;
    nv = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (o_valid || o_busy) nv++;
    end
    check_eq("idle_after_rst", nv, 0);
    last_q = 0;
    run_div(45, 0, 7, 0, 0);

    for (int i = 0; i < 40; i++) begin
      run_div(int'($urandom_range(0, 63)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uns_div.md
# uns_div

Sequential unsigned divider that runs the accumulator datapath in the subtractive direction. It divides a 6-bit unsigned dividend by a divisor chosen with the same `i_sel` operand-selection scheme as the unsigned accumulator. It produces a 6-bit quotient and 4-bit remainder by restoring shift-subtract, one quotient bit per clock, with a start/valid handshake. It sits beside the accumulator in the GP01 arithmetic lab and consumes the accumulator's 6-bit output as its dividend.

## Interface
Parameters:
- none; widths fixed by shared package constants (dividend 6, operand 3, divisor 4).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- i_rst_n  input  1  asynchronous reset, active low.
- i_start  input  1  request; sampled only in IDLE.
- i_dividend  input  6  unsigned dividend.
- i_data2  input  3  operand A.
- i_data1  input  3  operand B.
- i_sel  input  2  divisor select: 00 → {0,i_data2}; 01 → i_data2+i_data1 (4-bit, no truncation); 10 → {0,i_data1}; 11 → 0.
- o_quot  output  6  quotient.
- o_rem  output  4  remainder.
- o_busy  output  1  high in RUN.
- o_valid  output  1  one-cycle pulse; result valid.
- o_dbz  output  1  divide-by-zero flag of last result.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE, i_start=1:
  - capture dividend and selected divisor.
  - clear partial remainder (5 bits) and quotient register.
  - bit counter ← 5.
  - divisor ≠ 0 → RUN; divisor = 0 → DONE.
- IDLE, i_start=0: hold.
- RUN, each edge:
  - pr = {rem[3:0], dividend bit[counter]}.
  - pr ≥ divisor → rem ← pr − divisor, quotient bit ← 1; else rem ← pr, bit ← 0.
  - counter = 0 → DONE; else counter − 1.
- DONE: o_valid=1 for exactly one cycle; next edge → IDLE unconditionally.
- Divide-by-zero: o_quot=6'h3F, o_rem=4'h0, o_dbz=1.
- Normal result: o_dbz=0.
- Output registers update only at result commit. They hold until the next accepted start; o_quot/o_rem are not cleared by starting a new division.
- Operands change after the capture edge: no effect on the running division.
- Arithmetic rules:
  - divisor max 14.
  - remainder < divisor, fits 4 bits.
  - partial remainder compare is 5-bit.
  - quotient max 63 (divisor 1).

## Timing
- Reset values (asynchronous, any state): state IDLE, o_quot=0, o_rem=0, o_busy=0, o_valid=0, o_dbz=0, internal registers 0.
- Normal latency: start sampled at edge E0; o_busy high after E0 through E6; result visible and o_valid high in the cycle after E6 (7 edges start→valid).
- Divide-by-zero latency: o_valid high in the cycle after E0.
- i_start in RUN or DONE: ignored, not queued.
- i_start held high continuously: a new division is accepted on the first IDLE edge, one cycle after the o_valid cycle.
- Back-to-back throughput: one result per 8 cycles (normal), per 2 cycles (dbz).
- Reset asserted mid-RUN: operation aborted, no o_valid. After deassertion, waits in IDLE for a new start.

## Structure
- Package uns_div_pkg:
  - state encoding localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - width constants DIVIDEND_W=6, OP_W=3, DIVISOR_W=4.
  - counter width 3.
  - dbz quotient constant 6'h3F.
- Sub-module uns_div_sel: combinational divisor mux (i_sel, i_data2, i_data1 → 4-bit divisor). It shares the exact select semantics of the accumulator input mux.
- Top uns_div holds the FSM, counter, shift-subtract datapath and output registers.

## Test plan
- sel=00, data2=7, dividend=45, start → o_valid 7 edges later, o_quot=6, o_rem=3, o_dbz=0; o_busy high 6 cycles.
- sel=01, data2=7, data1=7 (divisor 14), dividend=63 → o_quot=4, o_rem=7; then sel=10, data1=1, dividend=63 → o_quot=63, o_rem=0.
- sel=11, dividend=20 → o_valid in the cycle after start edge, o_quot=6'h3F, o_rem=0, o_dbz=1; the next normal division clears o_dbz.
- Dividend < divisor: sel=00, data2=6, dividend=5 → o_quot=0, o_rem=5. Dividend=0 → o_quot=0, o_rem=0.
- Start pulses and operand changes during RUN → ignored; the result matches the captured operands. i_start held high → second result accepted one cycle after the first o_valid.
- Reset asserted at RUN cycle 3 → all outputs 0 immediately, no o_valid. Post-reset start 45/7 → 6 r 3.
